// File: rtl/h264_intra4x4_sched_if.sv
// Handshake/bus bundle between the frame sequencer, the pixel source FIFO,
// intra4x4 and recon. "slave" is the sequencer side, "master" the environment.
interface h264_intra4x4_sched_if;
   logic        START;
   logic        SRC_VALID;
   logic [31:0] SRC_DATA;
   logic        SRC_READ;
   logic        NEWSLICE;
   logic        NEWLINE;
   logic        STROBEI;
   logic [31:0] DATAI;
   logic        READYI;
   logic        FBSTROBE;
   logic        CHREADY;
   logic [7:0]  MBX;
   logic [7:0]  MBY;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   modport slave (
      input  START, SRC_VALID, SRC_DATA, READYI, FBSTROBE, CHREADY,
      output SRC_READ, NEWSLICE, NEWLINE, STROBEI, DATAI, MBX, MBY, BUSY, DONE, ERR
   );

   modport master (
      output START, SRC_VALID, SRC_DATA, READYI, FBSTROBE, CHREADY,
      input  SRC_READ, NEWSLICE, NEWLINE, STROBEI, DATAI, MBX, MBY, BUSY, DONE, ERR
   );
endinterface

// File: rtl/h264_intra4x4_sched.sv
// Frame-level macroblock sequencer for intra4x4: raster-scans MBs, streams 64
// luma words per MB from the source FIFO, then waits for 16 recon feedback
// strobes plus CHREADY before moving on.
// Optional WAITFB watchdog enabled by defining H264_SCHED_TIMEOUT_EN.
module h264_intra4x4_sched #(
   parameter int unsigned MB_COLS    = 11,
   parameter int unsigned MB_ROWS    = 9,
   parameter int unsigned FB_TIMEOUT = 1023
) (
   input logic                   CLK,
   input logic                   RESET,
   h264_intra4x4_sched_if.slave  bus
);

   typedef enum logic [2:0] {StIdle, StSlice, StLine, StFeed, StWaitFb, StNext} state_e;

   state_e      state_q, state_d;
   logic [5:0]  word_cnt_q, word_cnt_d;
   logic [4:0]  fb_cnt_q, fb_cnt_d;
   logic [7:0]  mbx_q, mbx_d;
   logic [7:0]  mby_q, mby_d;
   logic        strobe;
   logic        done;

`ifdef H264_SCHED_TIMEOUT_EN
   logic [9:0]  wd_q, wd_d;
   logic        err_q, err_d;
`endif

   // State and counter registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         fb_cnt_q   <= '0;
         mbx_q      <= '0;
         mby_q      <= '0;
`ifdef H264_SCHED_TIMEOUT_EN
         wd_q       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         fb_cnt_q   <= fb_cnt_d;
         mbx_q      <= mbx_d;
         mby_q      <= mby_d;
`ifdef H264_SCHED_TIMEOUT_EN
         wd_q       <= wd_d;
         err_q      <= err_d;
`endif
      end
   end

   // Next-state, counters and strobe/done generation
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      fb_cnt_d   = fb_cnt_q;
      mbx_d      = mbx_q;
      mby_d      = mby_q;
      strobe     = 1'b0;
      done       = 1'b0;
`ifdef H264_SCHED_TIMEOUT_EN
      wd_d       = '0;
      err_d      = err_q;
`endif

      // Feedback may overlap the feed phase; saturate at 16 per MB
      if ((state_q == StFeed || state_q == StWaitFb) && bus.FBSTROBE && fb_cnt_q != 5'd16) begin
         fb_cnt_d = fb_cnt_q + 5'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.START) begin
               state_d = StSlice;
               mbx_d   = '0;
               mby_d   = '0;
            end
         end
         StSlice: state_d = StLine;
         StLine: begin
            state_d    = StFeed;
            word_cnt_d = '0;
            fb_cnt_d   = '0;
         end
         StFeed: begin
            strobe = bus.READYI & bus.SRC_VALID;
            if (strobe) begin
               word_cnt_d = word_cnt_q + 6'd1;
               if (word_cnt_q == 6'd63) state_d = StWaitFb;
            end
         end
         StWaitFb: begin
            if (fb_cnt_q == 5'd16 && bus.CHREADY) begin
               state_d = StNext;
            end
`ifdef H264_SCHED_TIMEOUT_EN
            else if (bus.FBSTROBE) begin
               wd_d = '0;
            end else if (wd_q == 10'(FB_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
               mbx_d   = '0;
               mby_d   = '0;
            end else begin
               wd_d = wd_q + 10'd1;
            end
`endif
         end
         StNext: begin
            if (mbx_q < 8'(MB_COLS - 1)) begin
               mbx_d      = mbx_q + 8'd1;
               state_d    = StFeed;
               word_cnt_d = '0;
               fb_cnt_d   = '0;
            end else begin
               mbx_d = '0;
               if (mby_q < 8'(MB_ROWS - 1)) begin
                  mby_d   = mby_q + 8'd1;
                  state_d = StLine;
               end else begin
                  mby_d   = '0;
                  done    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.STROBEI  = strobe;
   assign bus.SRC_READ = strobe;
   // Gate the passthrough so DATAI reads zero outside the feed phase
   assign bus.DATAI    = (state_q == StFeed) ? bus.SRC_DATA : '0;
   assign bus.NEWSLICE = (state_q == StSlice);
   assign bus.NEWLINE  = (state_q == StLine);
   assign bus.BUSY     = (state_q != StIdle);
   assign bus.DONE     = done;
   assign bus.MBX      = mbx_q;
   assign bus.MBY      = mby_q;

`ifdef H264_SCHED_TIMEOUT_EN
   assign bus.ERR = err_q;
`else
   logic unused_fb_timeout;
   assign unused_fb_timeout = |FB_TIMEOUT;
   assign bus.ERR = 1'b0;
`endif

endmodule

// File: tb/tb_h264_intra4x4_sched.sv
// Directed bench: 1x1-MB instance for sequencing/backpressure/feedback/reset,
// 2x2-MB instance for line wrap. Inputs change and outputs are sampled
// around the falling edge.
module tb_h264_intra4x4_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   h264_intra4x4_sched_if ia ();
   h264_intra4x4_sched_if ib ();

   h264_intra4x4_sched #(.MB_COLS(1), .MB_ROWS(1), .FB_TIMEOUT(20)) dut_a (
      .CLK   (clk),
      .RESET (rst),
      .bus   (ia.slave)
   );

   h264_intra4x4_sched #(.MB_COLS(2), .MB_ROWS(2), .FB_TIMEOUT(20)) dut_b (
      .CLK   (clk),
      .RESET (rst),
      .bus   (ib.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Run statistics filled in by run_a
   int n_slice, n_line, n_strobe, n_done;
   int slice_cyc, line_cyc, first_strobe, last_strobe, done_cyc, err_cyc;
   int idx;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame on dut_a: START at cycle 0, then ncyc cycles of stimulus.
   task automatic run_a(input int ncyc, input bit toggle, input int fb_start, input int fb_num,
                        input int chr_start, input int restart_cyc);
      n_slice = 0; n_line = 0; n_strobe = 0; n_done = 0;
      slice_cyc = -1; line_cyc = -1; first_strobe = -1; last_strobe = -1;
      done_cyc = -1; err_cyc = -1; idx = 0;
      @(negedge clk);
      ia.START     = 1'b1;
      ia.SRC_VALID = 1'b1;
      ia.READYI    = 1'b1;
      ia.FBSTROBE  = 1'b0;
      ia.CHREADY   = (chr_start <= 0);
      ia.SRC_DATA  = 32'd0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         ia.START    = (c == restart_cyc);
         ia.READYI   = toggle ? c[0] : 1'b1;
         ia.FBSTROBE = (c >= fb_start && c < fb_start + fb_num);
         ia.CHREADY  = (c >= chr_start);
         ia.SRC_DATA = idx;
         #1;
         if (ia.NEWSLICE) begin n_slice++; slice_cyc = c; end
         if (ia.NEWLINE) begin n_line++; line_cyc = c; end
         if (ia.STROBEI) begin
            if (n_strobe == 0) first_strobe = c;
            last_strobe = c;
            n_strobe++;
            check_eq("datai", ia.DATAI, idx);
            idx++;
         end
         if (ia.DONE) begin n_done++; done_cyc = c; end
         if (ia.ERR && err_cyc < 0) err_cyc = c;
      end
      ia.START    = 1'b0;
      ia.FBSTROBE = 1'b0;
   endtask

   task automatic check_idle_a(input string tag);
      check_eq({tag, "_busy"},  ia.BUSY, 0);
      check_eq({tag, "_strb"},  ia.STROBEI, 0);
      check_eq({tag, "_read"},  ia.SRC_READ, 0);
      check_eq({tag, "_slice"}, ia.NEWSLICE, 0);
      check_eq({tag, "_line"},  ia.NEWLINE, 0);
      check_eq({tag, "_done"},  ia.DONE, 0);
      check_eq({tag, "_err"},   ia.ERR, 0);
      check_eq({tag, "_datai"}, ia.DATAI, 0);
      check_eq({tag, "_mbx"},   ia.MBX, 0);
      check_eq({tag, "_mby"},   ia.MBY, 0);
   endtask

   initial begin
      logic [15:0] mb_seen [4];
      int nb_line, nb_done, nb_done_cyc, nb_words, nb_mbs;

      ia.START = 0; ia.SRC_VALID = 1; ia.SRC_DATA = 32'h1234; ia.READYI = 1;
      ia.FBSTROBE = 0; ia.CHREADY = 1;
      ib.START = 0; ib.SRC_VALID = 0; ib.SRC_DATA = 0; ib.READYI = 0;
      ib.FBSTROBE = 0; ib.CHREADY = 0;

      // Reset state, with inputs that would otherwise strobe
      repeat (2) @(negedge clk);
      #1;
      check_idle_a("rst");
      @(negedge clk);
      rst = 1'b0;

      // Single MB, 20 feedback strobes during feed (saturates at 16)
      run_a(80, 1'b0, 10, 20, 0, 0);
      check_eq("s_slice_n",   n_slice, 1);
      check_eq("s_slice_cyc", slice_cyc, 1);
      check_eq("s_line_n",    n_line, 1);
      check_eq("s_line_cyc",  line_cyc, 2);
      check_eq("s_strobes",   n_strobe, 64);
      check_eq("s_first",     first_strobe, 3);
      check_eq("s_last",      last_strobe, 66);
      check_eq("s_done_n",    n_done, 1);
      check_eq("s_done_cyc",  done_cyc, 68);
      check_eq("s_busy_end",  ia.BUSY, 0);

      // Backpressure on READYI; a second START mid-frame is ignored
      run_a(140, 1'b1, 10, 16, 0, 20);
      check_eq("bp_slice_n", n_slice, 1);
      check_eq("bp_strobes", n_strobe, 64);
      check_eq("bp_first",   first_strobe, 3);
      check_eq("bp_last",    last_strobe, 129);
      check_eq("bp_done",    done_cyc, 131);

      // 16th feedback coincides with the 64th word
      run_a(80, 1'b0, 51, 16, 0, 0);
      check_eq("ov_done", done_cyc, 68);

      // Feedback gating: CHREADY=1 throughout, 16th pulse at cycle 85
      run_a(100, 1'b0, 70, 16, 0, 0);
      check_eq("fg_done", done_cyc, 87);
      check_eq("fg_done_n", n_done, 1);

      // All 16 seen by cycle 86 but CHREADY held low until cycle 90
      run_a(100, 1'b0, 70, 16, 90, 0);
      check_eq("ch_done", done_cyc, 91);

      // Reset after word 30 is fed, then a clean restart
      run_a(32, 1'b0, 0, 0, 0, 0);
      check_eq("rm_words", n_strobe, 30);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_a("rm");
      @(negedge clk);
      rst = 1'b0;
      run_a(80, 1'b0, 10, 16, 0, 0);
      check_eq("rs_slice",   slice_cyc, 1);
      check_eq("rs_strobes", n_strobe, 64);
      check_eq("rs_done",    done_cyc, 68);

      // Line wrap on the 2x2 instance; feedback held high (saturates each MB)
      nb_line = 0; nb_done = 0; nb_done_cyc = -1; nb_words = 0; nb_mbs = 0;
      @(negedge clk);
      ib.START = 1; ib.SRC_VALID = 1; ib.READYI = 1; ib.FBSTROBE = 1; ib.CHREADY = 1;
      for (int c = 1; c <= 280; c++) begin
         @(negedge clk);
         ib.START = 0;
         #1;
         if (ib.NEWLINE) nb_line++;
         if (ib.DONE) begin nb_done++; nb_done_cyc = c; end
         if (ib.STROBEI) begin
            if (nb_words % 64 == 0 && nb_mbs < 4) begin
               mb_seen[nb_mbs] = {ib.MBY, ib.MBX};
               nb_mbs++;
            end
            nb_words++;
         end
      end
      ib.FBSTROBE = 0;
      check_eq("lw_newline", nb_line, 2);
      check_eq("lw_done_n",  nb_done, 1);
      check_eq("lw_done",    nb_done_cyc, 267);
      check_eq("lw_words",   nb_words, 256);
      check_eq("lw_mbs",     nb_mbs, 4);
      if (nb_mbs == 4) begin
         check_eq("lw_mb0", mb_seen[0], 16'h0000);
         check_eq("lw_mb1", mb_seen[1], 16'h0001);
         check_eq("lw_mb2", mb_seen[2], 16'h0100);
         check_eq("lw_mb3", mb_seen[3], 16'h0101);
      end
      check_eq("lw_busy", ib.BUSY, 0);
      check_eq("lw_mbxy", {ib.MBY, ib.MBX}, 0);

`ifdef H264_SCHED_TIMEOUT_EN
      // No feedback: watchdog fires after 20 WAITFB cycles (67..86)
      run_a(100, 1'b0, 0, 0, 0, 0);
      check_eq("to_err_cyc", err_cyc, 87);
      check_eq("to_done_n",  n_done, 0);
      check_eq("to_busy",    ia.BUSY, 0);
      check_eq("to_err",     ia.ERR, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("to_err_clr", ia.ERR, 0);
      @(negedge clk);
      rst = 1'b0;
`else
      check_eq("no_err", ia.ERR, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
